// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: raster timing generator with bars/checker/ramp/moving-box test patterns.
// Define BORDER_EN to overlay a 1-pixel white border on the active area in every mode.
module video_timing_pattern_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   COORD_W    = 12,
    parameter int   CHECK_LOG2 = 5,
    parameter int   BOX_SIZE   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode_sel,
    output logic               hsync,
    output logic               vsync,
    output logic               vde,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               sof,
    output logic [7:0]         frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SS     = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SE     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SS     = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SE     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] BAR_DIV  = COORD_W'(BAR_W);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(7 * BAR_W);
    localparam logic [COORD_W-1:0] BOX      = COORD_W'(BOX_SIZE);
    localparam logic [COORD_W-1:0] BX_MAX   = COORD_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W-1:0] BY_MAX   = COORD_W'(V_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    logic               run;
    logic [COORD_W-1:0] h_cnt, v_cnt, bx, by;
    logic               dx, dy;
    logic [1:0]         mode;
    logic               h_end, frame_end, active, in_box;
    logic [2:0]         bar;
    logic [23:0]        pix;

    assign h_end     = h_cnt == H_LAST;
    assign frame_end = h_end && v_cnt == V_LAST;
    assign active    = h_cnt < H_ACT && v_cnt < V_ACT;
    assign in_box    = h_cnt >= bx && h_cnt < bx + BOX && v_cnt >= by && v_cnt < by + BOX;

    // Bar colours decode straight from the index bits: r = ~b1, g = ~b2, b = ~b0.
    always_comb begin
        bar = h_cnt >= BAR_LAST ? 3'd7 : 3'(h_cnt / BAR_DIV);
        pix = mode == 2'd0 ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
            : mode == 2'd1 ? {24{h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]}}
            : mode == 2'd2 ? {3{h_cnt[7:0]}}
            : (in_box ? 24'hFFFFFF : 24'h000040);
`ifdef BORDER_EN
        if (h_cnt == '0 || h_cnt == H_ACT - ONE || v_cnt == '0 || v_cnt == V_ACT - ONE)
            pix = 24'hFFFFFF;
`endif
    end

    // The first edge after release only arms the generator, so pixel (0,0) lands on the second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            vde       <= 1'b0;
            sof       <= 1'b0;
            x         <= '0;
            y         <= '0;
            {red, green, blue} <= '0;
            frame_cnt <= '0;
            mode      <= '0;
            bx        <= '0;
            by        <= '0;
            dx        <= 1'b1;
            dy        <= 1'b1;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + ONE;
            v_cnt <= h_end ? (v_cnt == V_LAST ? '0 : v_cnt + ONE) : v_cnt;
            hsync <= (h_cnt >= H_SS && h_cnt < H_SE) ? SYNC_POL : ~SYNC_POL;
            vsync <= (v_cnt >= V_SS && v_cnt < V_SE) ? SYNC_POL : ~SYNC_POL;
            vde   <= active;
            sof   <= h_cnt == '0 && v_cnt == '0;
            x     <= h_cnt;
            y     <= v_cnt;
            {red, green, blue} <= active ? pix : '0;
            if (frame_end) begin
                mode      <= mode_sel;
                frame_cnt <= frame_cnt + 8'd1;
                if (dx ? bx == BX_MAX : bx == '0) dx <= ~dx;
                else bx <= dx ? bx + ONE : bx - ONE;
                if (dy ? by == BY_MAX : by == '0) dy <= ~dy;
                else by <= dy ? by + ONE : by - ONE;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: scoreboard bench; a behavioural raster model predicts every output cycle.
// A second tiny instance exercises frame_cnt wrap in a short run.
module tb_video_timing_pattern_gen;
    localparam int HA = 40, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 1;
    localparam int BOX = 8, CL = 5, CW = 12;
    localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic hs, vs, de, sof;
        logic [CW-1:0] x, y;
        logic [23:0] rgb;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0, reset_n = 1'b0, rst_s_n = 1'b0;
    logic [1:0] mode_sel = 2'd3;
    logic hsync, vsync, vde, sof;
    logic [CW-1:0] x, y;
    logic [7:0] red, green, blue, frame_cnt;
    logic [23:0] rgb_now;
    logic s_hs, s_vs, s_de, s_sof;
    logic [7:0] s_x, s_y, s_r, s_g, s_b, s_fc;

    int checks = 0, failures = 0;
    obs_t exp_q[$];
    int mh, mv, mbx, mby, mdx, mdy, mmode, mfc;
    bit armed, s_done;
    int cur_h, cur_v;

    assign rgb_now = {red, green, blue};
    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .COORD_W(CW), .CHECK_LOG2(CL), .BOX_SIZE(BOX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel),
        .hsync(hsync), .vsync(vsync), .vde(vde), .x(x), .y(y),
        .red(red), .green(green), .blue(blue), .sof(sof), .frame_cnt(frame_cnt)
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .COORD_W(8), .CHECK_LOG2(1), .BOX_SIZE(2)
    ) dut_s (
        .clk(clk), .reset_n(rst_s_n), .mode_sel(2'd0),
        .hsync(s_hs), .vsync(s_vs), .vde(s_de), .x(s_x), .y(s_y),
        .red(s_r), .green(s_g), .blue(s_b), .sof(s_sof), .frame_cnt(s_fc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mbx = 0; mby = 0; mdx = 1; mdy = 1; mmode = 0; mfc = 0; armed = 0;
    endtask

    function automatic obs_t idle();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic logic [23:0] pat(input int h, input int v);
        logic [23:0] c;
        logic [7:0] r;
        r = 8'(h);
        case (mmode)
            0: c = BARS[(h / (HA / 8)) > 7 ? 7 : h / (HA / 8)];
            1: c = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            2: c = {r, r, r};
            default: c = (h >= mbx && h < mbx + BOX && v >= mby && v < mby + BOX) ? 24'hFFFFFF : 24'h000040;
        endcase
`ifdef BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    // One pixel clock: predict at the edge, compare on the following falling edge.
    task automatic step();
        obs_t e, g;
        @(posedge clk);
        cur_h = -1;
        cur_v = -1;
        if (!reset_n) begin
            model_reset();
            e = idle();
        end else if (!armed) begin
            armed = 1;
            e = idle();
        end else begin
            e.hs  = !(mh >= HA + HF && mh < HA + HF + HS);
            e.vs  = !(mv >= VA + VF && mv < VA + VF + VS);
            e.de  = mh < HA && mv < VA;
            e.sof = mh == 0 && mv == 0;
            e.x   = CW'(mh);
            e.y   = CW'(mv);
            e.rgb = e.de ? pat(mh, mv) : 24'h0;
            cur_h = mh;
            cur_v = mv;
            if (mh == HT - 1 && mv == VT - 1) begin
                mmode = int'(mode_sel);
                mfc = (mfc + 1) % 256;
                if ((mdx > 0 && mbx + BOX == HA) || (mdx < 0 && mbx == 0)) mdx = -mdx;
                else mbx += mdx;
                if ((mdy > 0 && mby + BOX == VA) || (mdy < 0 && mby == 0)) mdy = -mdy;
                else mby += mdy;
            end
            e.fc = 8'(mfc);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        g = {hsync, vsync, vde, sof, x, y, red, green, blue, frame_cnt};
        e = exp_q.pop_front();
        if (!e.de) begin
            g.x = e.x;
            g.y = e.y;
        end
        check("pixel", g, e);
    endtask

    initial begin
        int n;
        n = 0;
        wait (rst_s_n);
        while (n < 19713) begin
            @(posedge clk);
            n++;
            if (n == 77 || n == 78 || n == 19712 || n == 19713) begin
                @(negedge clk);
                check($sformatf("small_fc_%0d", n), s_fc, n == 78 ? 1 : n == 19712 ? 255 : 0);
            end
        end
        s_done = 1;
    end

    initial begin
        int n_de, n_hs, n_vs, first_hs, bx_seen;
        model_reset();
        repeat (3) step();
        check("rst_sync", {hsync, vsync}, 2'b11);
        check("rst_vde", vde, 0);
        check("rst_rgb", rgb_now, 0);
        check("rst_fc", frame_cnt, 0);
        reset_n = 1'b1;
        rst_s_n = 1'b1;
        mode_sel = 2'd0;
        step();
        check("sof_edge1", sof, 0);
        step();
        check("sof_edge2", {sof, x, y}, {1'b1, 24'h0});
        n_de = 0; n_hs = 0; n_vs = 0; first_hs = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            n_de += int'(vde);
            n_hs += int'(!hsync);
            n_vs += int'(!vsync);
            if (!hsync && first_hs < 0) first_hs = cur_h;
            if (cur_v == 5 && cur_h == 0) mode_sel = 2'd1;
            if (cur_v == 0 && cur_h == 0) check("bar_x0", rgb_now, 24'hFFFFFF);
            if (cur_v == 1 && cur_h == 5) check("bar_x5", rgb_now, 24'hFFFF00);
            if (cur_v == 3 && cur_h == 34) check("bar_x34", rgb_now, 24'h0000FF);
            if (cur_v == 2 && cur_h == 39) check("bar_x39", rgb_now, 24'h000000);
            if (cur_v == 2 && cur_h == 44) check("blank_rgb", rgb_now, 24'h000000);
            if (cur_v == 6 && cur_h == 32) check("bars_after_sel", rgb_now, 24'h0000FF);
        end
        check("frame_vde", n_de, HA * VA);
        check("hsync_low", n_hs, HS * VT);
        check("vsync_low", n_vs, VS * HT);
        check("hsync_start", first_hs, HA + HF);
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == 0) mode_sel = 2'd3;
            if (cur_v == 0 && cur_h == 0) check("chk_0_0", rgb_now, 24'h000000);
            if (cur_v == 0 && cur_h == 32) check("chk_32_0", rgb_now, 24'hFFFFFF);
        end
        for (int f = 3; f <= 35; f++) begin
            bx_seen = -1;
            for (int i = 0; i < FRAME; i++) begin
                step();
                if (vde && rgb_now == 24'hFFFFFF && cur_h > 0 && cur_h < HA - 1 && cur_v > 0 && cur_v < VA - 1
                    && (bx_seen < 0 || cur_h < bx_seen)) bx_seen = cur_h;
            end
            if (f == 33) check("bx_peak", bx_seen, 32);
            if (f == 34) check("bx_hold", bx_seen, 32);
            if (f == 35) check("bx_back", bx_seen, 31);
        end
        mode_sel = 2'd2;
        for (int i = 0; i < FRAME && !(cur_h == 30 && cur_v == 8); i++) step();
        #2 reset_n = 1'b0;
        #1;
        check("async_vde", vde, 0);
        check("async_sync", {hsync, vsync}, 2'b11);
        check("async_rgb", rgb_now, 0);
        check("async_fc", frame_cnt, 0);
        check("async_sof_xy", {sof, x, y}, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("restart_edge1", sof, 0);
        step();
        check("sof_restart", {sof, x, y}, {1'b1, 24'h0});
        check("restart_bars", rgb_now, 24'hFFFFFF);
        repeat (FRAME - 1) step();
        for (int i = 0; i < FRAME; i++) begin
            step();
`ifdef BORDER_EN
            if (cur_v == 5 && cur_h == 0) check("ramp_border", rgb_now, 24'hFFFFFF);
`else
            if (cur_v == 5 && cur_h == 0) check("ramp_border", rgb_now, 24'h000000);
`endif
            if (cur_v == 5 && cur_h == 7) check("ramp_7", rgb_now, 24'h070707);
            if (cur_v == 1 && cur_h == 20) check("ramp_20", rgb_now, 24'h141414);
        end
        for (int i = 0; i < 30000 && !s_done; i++) step();
        check("small_done", s_done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
